// File: rtl/qpu_exu_evt_wbck_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : qpu_exu_evt_wbck_queue_pkg
// Brief  : Shared widths and helpers for the event write-back queue.
// Rev    : 1.0  initial release
// ============================================================================
package qpu_exu_evt_wbck_queue_pkg;

  localparam int QPU_TIME_WIDTH                = 16;
  localparam int QPU_EVENT_WIRE_WIDTH          = 16;
  localparam int QPU_EVENT_NUM                 = 4;
  localparam int QPU_TWO_QUBIT_GATE_LIST_WIDTH = 8;
  localparam int QPU_EVTQ_DEPTH                = 8;

  function automatic int evtq_entry_width(input int evt_w, input int opr_w,
                                          input int tqgl_w, input int time_w);
    return evt_w + opr_w + tqgl_w + time_w;
  endfunction

  // Occupancy counter needs one bit more than the index to represent "full".
  function automatic int evtq_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int QPU_EVTQ_ENTRY_WIDTH =
    evtq_entry_width(QPU_EVENT_WIRE_WIDTH, QPU_EVENT_NUM,
                     QPU_TWO_QUBIT_GATE_LIST_WIDTH, QPU_TIME_WIDTH);

endpackage
`default_nettype wire

// File: rtl/qpu_gnrl_fifo.sv
`default_nettype none
// ============================================================================
// Module : qpu_gnrl_fifo
// Brief  : Synchronous FIFO with wrap-bit pointers, head exposed combinationally.
// Rev    : 1.0  initial release
// ============================================================================
module qpu_gnrl_fifo
  import qpu_exu_evt_wbck_queue_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = evtq_cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] r_wptr;
  logic [CW-1:0] r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_push_en;
  logic          w_pop_en;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_en  = pop & ~empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_push_en = push & (~full | w_pop_en);
  assign cnt       = r_wptr - r_rptr;
  assign head_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_en) r_wptr <= r_wptr + 1'b1;
      if (w_pop_en)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_en & ~flush) r_mem[r_wptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/qpu_exu_evt_wbck_queue.sv
`default_nettype none
// ============================================================================
// Module : qpu_exu_evt_wbck_queue
// Brief  : Stamps write-back events with an accumulated time label and
//          releases them when the system timer reaches that label.
// Rev    : 1.0  initial release
// ============================================================================
module qpu_exu_evt_wbck_queue
  import qpu_exu_evt_wbck_queue_pkg::*;
#(
  parameter int TIME_W = QPU_TIME_WIDTH,
  parameter int EVT_W  = QPU_EVENT_WIRE_WIDTH,
  parameter int OPR_W  = QPU_EVENT_NUM,
  parameter int TQGL_W = QPU_TWO_QUBIT_GATE_LIST_WIDTH,
  parameter int DEPTH  = QPU_EVTQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   tmr_en,
  input  logic                   twbck_i_valid,
  output logic                   twbck_i_ready,
  input  logic [TIME_W-1:0]      twbck_i_data,
  input  logic                   ewbck_i_valid,
  output logic                   ewbck_i_ready,
  input  logic [EVT_W-1:0]       ewbck_i_data,
  input  logic [OPR_W-1:0]       ewbck_i_oprand,
  input  logic [TQGL_W-1:0]      ewbck_i_tqgl,
  output logic                   evt_o_valid,
  input  logic                   evt_o_ready,
  output logic [EVT_W-1:0]       evt_o_data,
  output logic [OPR_W-1:0]       evt_o_oprand,
  output logic [TQGL_W-1:0]      evt_o_tqgl,
  output logic [TIME_W-1:0]      evt_o_time,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   late_err
);

  localparam int ENT_W = evtq_entry_width(EVT_W, OPR_W, TQGL_W, TIME_W);

  logic [TIME_W-1:0] r_acc;
  logic [TIME_W-1:0] r_timer;
  logic              r_late_err;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_ready;
  logic              w_tfire;
  logic              w_efire;
  logic              w_due;
  logic [TIME_W-1:0] w_acc_next;
  logic [TIME_W-1:0] w_diff;
  logic [ENT_W-1:0]  w_push_ent;
  logic [ENT_W-1:0]  w_head_ent;
  logic [EVT_W-1:0]  w_head_data;
  logic [OPR_W-1:0]  w_head_opr;
  logic [TQGL_W-1:0] w_head_tqgl;
  logic [TIME_W-1:0] w_head_time;

  assign w_ready       = ~w_full | w_pop;
  assign twbck_i_ready = w_ready;
  assign ewbck_i_ready = w_ready;
  assign w_tfire       = twbck_i_valid & w_ready;
  assign w_efire       = ewbck_i_valid & w_ready;

  // The label seen by an event includes a time delta arriving in the same beat.
  assign w_acc_next = r_acc + (w_tfire ? twbck_i_data : '0);
  assign w_push     = w_efire & (|ewbck_i_oprand) & ~flush;
  assign w_push_ent = {ewbck_i_data, ewbck_i_oprand, ewbck_i_tqgl, w_acc_next};

  assign {w_head_data, w_head_opr, w_head_tqgl, w_head_time} = w_head_ent;

  // Wrap-safe comparison: head is due once timer is at or past its label.
  assign w_diff = r_timer - w_head_time;
  assign w_due  = ~w_diff[TIME_W-1];

  assign evt_o_valid  = ~w_empty & w_due;
  assign evt_o_data   = w_empty ? '0 : w_head_data;
  assign evt_o_oprand = w_empty ? '0 : w_head_opr;
  assign evt_o_tqgl   = w_empty ? '0 : w_head_tqgl;
  assign evt_o_time   = w_empty ? '0 : w_head_time;
  assign w_pop        = evt_o_valid & evt_o_ready;
  assign late_err     = r_late_err;

  qpu_gnrl_fifo #(
    .DW    (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_push_ent),
    .pop       (w_pop),
    .head_data (w_head_ent),
    .full      (w_full),
    .empty     (w_empty),
    .cnt       (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_timer    <= '0;
      r_late_err <= 1'b0;
    end else if (flush) begin
      r_acc      <= '0;
      r_timer    <= '0;
      r_late_err <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      if (tmr_en) r_timer <= r_timer + 1'b1;
      if (w_pop && (r_timer != w_head_time)) r_late_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qpu_exu_evt_wbck_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_qpu_exu_evt_wbck_queue
// Brief  : Self-checking bench with a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_qpu_exu_evt_wbck_queue;

  localparam int TIME_W = 8;
  localparam int EVT_W  = 16;
  localparam int OPR_W  = 4;
  localparam int TQGL_W = 8;
  localparam int DEPTH  = 8;
  localparam int MODT   = 1 << TIME_W;

  logic clk = 1'b0;
  logic rst_n, flush, tmr_en;
  logic twbck_i_valid, twbck_i_ready;
  logic [TIME_W-1:0] twbck_i_data;
  logic ewbck_i_valid, ewbck_i_ready;
  logic [EVT_W-1:0]  ewbck_i_data;
  logic [OPR_W-1:0]  ewbck_i_oprand;
  logic [TQGL_W-1:0] ewbck_i_tqgl;
  logic evt_o_valid, evt_o_ready;
  logic [EVT_W-1:0]  evt_o_data;
  logic [OPR_W-1:0]  evt_o_oprand;
  logic [TQGL_W-1:0] evt_o_tqgl;
  logic [TIME_W-1:0] evt_o_time;
  logic [$clog2(DEPTH):0] cnt;
  logic late_err;

  qpu_exu_evt_wbck_queue #(
    .TIME_W(TIME_W), .EVT_W(EVT_W), .OPR_W(OPR_W), .TQGL_W(TQGL_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .tmr_en(tmr_en),
    .twbck_i_valid(twbck_i_valid), .twbck_i_ready(twbck_i_ready), .twbck_i_data(twbck_i_data),
    .ewbck_i_valid(ewbck_i_valid), .ewbck_i_ready(ewbck_i_ready), .ewbck_i_data(ewbck_i_data),
    .ewbck_i_oprand(ewbck_i_oprand), .ewbck_i_tqgl(ewbck_i_tqgl),
    .evt_o_valid(evt_o_valid), .evt_o_ready(evt_o_ready), .evt_o_data(evt_o_data),
    .evt_o_oprand(evt_o_oprand), .evt_o_tqgl(evt_o_tqgl), .evt_o_time(evt_o_time),
    .cnt(cnt), .late_err(late_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [EVT_W-1:0]  d;
    logic [OPR_W-1:0]  o;
    logic [TQGL_W-1:0] q;
    int                lbl;
  } ent_t;

  ent_t m_q[$];
  int   m_acc;
  int   m_timer;
  bit   m_late;

  typedef struct {
    bit tv; int td; bit ev; int eo;
    bit e_valid; int e_cnt; bit e_late; int e_time;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_acc   = 0;
    m_timer = 0;
    m_late  = 0;
  endtask

  task automatic drv(input bit tv, input int td, input bit ev, input int eo, input bit rdy);
    twbck_i_valid  = tv;
    twbck_i_data   = TIME_W'(td);
    ewbck_i_valid  = ev;
    ewbck_i_oprand = OPR_W'(eo);
    ewbck_i_data   = EVT_W'($urandom);
    ewbck_i_tqgl   = TQGL_W'($urandom);
    evt_o_ready    = rdy;
  endtask

  // One clock: compare DUT against the model at the negedge, then advance the model.
  task automatic cycle();
    ent_t h;
    bit   due, pop, rdy, tf, ef;
    int   an;
    @(negedge clk);
    due = (m_q.size() > 0) && (((m_timer - m_q[0].lbl) % MODT + MODT) % MODT < MODT / 2);
    pop = due && evt_o_ready;
    rdy = (m_q.size() < DEPTH) || pop;
    h   = (m_q.size() > 0) ? m_q[0] : '{d: '0, o: '0, q: '0, lbl: 0};
    chk("valid", evt_o_valid, due);
    chk("t_ready", twbck_i_ready, rdy);
    chk("e_ready", ewbck_i_ready, rdy);
    chk("cnt", cnt, m_q.size());
    chk("late_err", late_err, m_late);
    chk("data", evt_o_data, h.d);
    chk("oprand", evt_o_oprand, h.o);
    chk("tqgl", evt_o_tqgl, h.q);
    chk("time", evt_o_time, h.lbl);
    tf = twbck_i_valid && rdy;
    ef = ewbck_i_valid && rdy;
    an = (m_acc + (tf ? int'(twbck_i_data) : 0)) % MODT;
    if (flush) begin
      model_reset();
    end else begin
      if (pop) begin
        if (m_timer != m_q[0].lbl) m_late = 1;
        m_q.delete(0);
      end
      if (ef && ewbck_i_oprand != 0)
        m_q.push_back('{d: ewbck_i_data, o: ewbck_i_oprand, q: ewbck_i_tqgl, lbl: an});
      m_acc = an;
      if (tmr_en) m_timer = (m_timer + 1) % MODT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush_cycle();
    flush = 1'b1;
    drv(0, 0, 0, 0, 0);
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    int k;
    // {tv, td, ev, eo, exp valid, exp cnt, exp late, exp time}
    tbl[0]  = '{1, 5, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 5};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 5};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 0, 5};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 5};
    tbl[5]  = '{0, 0, 0, 0, 1, 1, 0, 5};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 7, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 2, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 12};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 12};
    tbl[12] = '{0, 0, 0, 0, 1, 1, 0, 12};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0; flush = 1'b0; tmr_en = 1'b0;
    drv(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", evt_o_valid, 0);
    chk("rst_t_ready", twbck_i_ready, 1);
    chk("rst_e_ready", ewbck_i_ready, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_late", late_err, 0);
    chk("rst_time", evt_o_time, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Labelled events, on-time issue and a dropped no-operand beat.
    tmr_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drv(tbl[i].tv, tbl[i].td, tbl[i].ev, tbl[i].eo, 1);
      #3;
      chk($sformatf("tbl%0d_valid", i), evt_o_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_late", i), late_err, tbl[i].e_late);
      chk($sformatf("tbl%0d_time", i), evt_o_time, tbl[i].e_time);
      cycle();
    end

    // Deltas 2,0,3: two events share label 2, the second issues late.
    flush_cycle();
    drv(1, 2, 1, 1, 1); cycle();
    drv(1, 0, 1, 1, 1); cycle();
    drv(1, 3, 1, 1, 1); cycle();
    drv(0, 0, 0, 0, 1);
    repeat (5) cycle();
    chk("seq2_late", late_err, 1);
    chk("seq2_cnt", cnt, 0);

    // Fill to DEPTH with the sink stalled, then pop while pushing.
    flush_cycle();
    tmr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drv(0, 0, 1, 3, 0); cycle();
    end
    drv(0, 0, 0, 0, 0);
    #3;
    chk("full_cnt", cnt, DEPTH);
    chk("full_e_ready", ewbck_i_ready, 0);
    cycle();
    drv(0, 0, 1, 5, 1);
    #3;
    chk("full_pop_ready", ewbck_i_ready, 1);
    cycle();
    drv(0, 0, 0, 0, 0);
    #3;
    chk("full_pushpop_cnt", cnt, DEPTH);
    cycle();
    drv(0, 0, 0, 0, 1);
    repeat (DEPTH + 1) cycle();
    tmr_en = 1'b1;

    // Label wraps past 2^TIME_W; issue waits for the timer to wrap too.
    flush_cycle();
    drv(1, MODT - 2, 0, 0, 1); cycle();
    drv(0, 0, 0, 0, 1);
    k = 0;
    while (m_timer != MODT - 6 && k < 2 * MODT) begin
      cycle(); k++;
    end
    drv(1, 4, 1, 1, 1); cycle();
    drv(0, 0, 0, 0, 1);
    k = 0;
    while (k < 20) begin
      #3;
      if (evt_o_valid) break;
      cycle(); k++;
    end
    chk("wrap_wait", k, 7);
    chk("wrap_label", evt_o_time, 2);
    cycle();

    // Flush clears entries, label, timer and the sticky error.
    flush_cycle();
    drv(0, 0, 1, 1, 0); cycle();
    drv(0, 0, 0, 0, 0); repeat (2) cycle();
    drv(0, 0, 0, 0, 1); cycle();
    drv(1, 1, 1, 2, 0); repeat (3) cycle();
    drv(0, 0, 0, 0, 0);
    k = 0;
    while (m_timer != 40 && k < 2 * MODT) begin
      cycle(); k++;
    end
    #3;
    chk("pre_flush_cnt", cnt, 3);
    chk("pre_flush_late", late_err, 1);
    flush = 1'b1;
    drv(1, 9, 1, 1, 0);
    cycle();
    flush = 1'b0;
    drv(0, 0, 0, 0, 0);
    #3;
    chk("post_flush_cnt", cnt, 0);
    chk("post_flush_late", late_err, 0);
    cycle();
    drv(0, 0, 1, 1, 0); cycle();
    drv(0, 0, 0, 0, 0);
    #3;
    chk("post_flush_label", evt_o_time, 0);
    chk("post_flush_due", evt_o_valid, 1);
    cycle();

    // Asynchronous reset in the middle of traffic.
    drv(1, 3, 1, 6, 0);
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", evt_o_valid, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_t_ready", twbck_i_ready, 1);
    chk("arst_e_ready", ewbck_i_ready, 1);
    chk("arst_time", evt_o_time, 0);
    chk("arst_data", evt_o_data, 0);
    tmr_en = 1'b0;
    drv(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tmr_en = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 49) == 0);
      drv($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 4) < 3,
          $urandom_range(0, 15), $urandom_range(0, 9) < 7);
      cycle();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
